// File: rtl/data_mem_responder.sv
// Single-outstanding load/store data memory with a fixed response latency.
// Define DMEM_ACCESS_CHECK_EN to reject misaligned or out-of-range addresses with resp_err.
module data_mem_responder #(
   parameter int LATENCY    = 2,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        trace_valid,
   output logic [31:0] trace_pc,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_data,
   output logic [1:0]  state_dbg
);
   // Handshakes: a request transfers when req_valid && req_ready at a rising edge;
   // a response transfers when resp_valid && resp_ready at a rising edge.
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic                  lat_we;
   logic [31:0]           lat_addr;
   logic [31:0]           lat_wdata;
   logic [3:0]            lat_be;
   logic [31:0]           lat_pc;
   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] idx;
   logic                  addr_err;
   logic [31:0]           merged;

   assign state_dbg = state;
   assign idx       = lat_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_ACCESS_CHECK_EN
   assign addr_err = (lat_addr[1:0] != 2'b00) || (|lat_addr[31:DEPTH_LOG2+2]);
`else
   assign addr_err = 1'b0;
`endif

   always_comb begin
      merged = mem[idx];
      for (int b = 0; b < 4; b++) begin
         if (lat_be[b]) merged[8*b +: 8] = lat_wdata[8*b +: 8];
      end
   end

   // WAIT always spans LATENCY+1 cycles so the response appears after edge N+1+LATENCY,
   // including LATENCY=0; the memory access happens on the edge that leaves WAIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
         lat_we      <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         lat_be      <= '0;
         lat_pc      <= '0;
         trace_valid <= 1'b0;
         trace_pc    <= '0;
         trace_addr  <= '0;
         trace_data  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         trace_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_be    <= req_be;
                  lat_pc    <= req_pc;
                  cnt       <= 4'(LATENCY);
                  req_ready <= 1'b0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= addr_err;
                  resp_rdata <= (lat_we || addr_err) ? 32'h0 : mem[idx];
                  if (lat_we && !addr_err) begin
                     mem[idx]    <= merged;
                     trace_valid <= 1'b1;
                     trace_pc    <= lat_pc;
                     trace_addr  <= lat_addr;
                     trace_data  <= merged;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a word-array model predicts every response
// and store trace; a monitor compares them, including response latency and stability.
module tb_data_mem_responder;
   localparam int LATENCY    = 2;
   localparam int DEPTH_LOG2 = 10;
   localparam int DEPTH      = 1 << DEPTH_LOG2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic [31:0] req_pc = '0;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [31:0] trace_addr;
   logic [31:0] trace_data;
   logic [1:0]  state_dbg;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [32:0] exp_q[$];
   int          exp_cyc_q[$];
   logic [95:0] trace_q[$];
   logic [31:0] mdl [DEPTH];
   logic        active = 1'b0;
   logic [32:0] cur = '0;
   int          cur_cyc = 0;
   logic        hold = 1'b0;

   data_mem_responder #(.LATENCY(LATENCY), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_pc(req_pc),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_addr(trace_addr),
      .trace_data(trace_data), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      exp_q.delete();
      exp_cyc_q.delete();
      trace_q.delete();
      active = 1'b0;
   endtask

   // response-side driver: random backpressure unless a stall is requested
   initial begin
      resp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         resp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // request driver: predicts the response from the model, then performs the handshake
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] pc);
      int          g;
      int          idx;
      logic        err;
      logic [31:0] word;
      logic [31:0] mask;
      g = 0;
      @(negedge clk);
      while (!req_ready && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
         return;
      end
      err = 1'b0;
`ifdef DMEM_ACCESS_CHECK_EN
      err = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
`endif
      idx  = int'(addr >> 2) % DEPTH;
      word = mdl[idx];
      if (err) begin
         exp_q.push_back({1'b1, 32'h0});
      end else if (we) begin
         mask = '0;
         for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
         word     = (word & ~mask) | (wdata & mask);
         mdl[idx] = word;
         exp_q.push_back({1'b0, 32'h0});
         trace_q.push_back({pc, addr, word});
      end else begin
         exp_q.push_back({1'b0, word});
      end
      exp_cyc_q.push_back(cyc + 2 + LATENCY);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      req_pc    = pc;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      req_pc    = $urandom;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || active) && g < 500) begin
         @(negedge clk);
         g++;
      end
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // monitor + scoreboard
   always @(negedge clk) begin
      if (reset && resp_valid) begin
         if (!active) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: got err=%0h rdata=%0h expected no response",
                        resp_err, resp_rdata);
            end else begin
               cur     = exp_q.pop_front();
               cur_cyc = exp_cyc_q.pop_front();
               active  = 1'b1;
               check("resp_latency", 64'(cyc), 64'(cur_cyc));
            end
         end
         if (active) begin
            check("resp_data", 64'({resp_err, resp_rdata}), 64'(cur));
            if (resp_ready) active = 1'b0;
         end
      end
      if (reset && trace_valid) begin
         $display("@%h: *%h <= %h", trace_pc, trace_addr, trace_data);
         if (trace_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_trace: got %h expected none", trace_data);
         end else begin
            check("trace", 64'({trace_addr, trace_data}), 64'(trace_q[0][63:0]));
            check("trace_pc", 64'(trace_pc), 64'(trace_q[0][95:64]));
            void'(trace_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          g;
      model_clear();
      repeat (3) @(negedge clk);
      #3 reset = 1'b1;
      @(negedge clk);
      check("reset_req_ready", 64'(req_ready), 64'd1);
      check("reset_resp_valid", 64'(resp_valid), 64'd0);
      check("reset_resp_rdata", 64'(resp_rdata), 64'd0);
      check("reset_resp_err", 64'(resp_err), 64'd0);

      issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h100);
      issue(1'b1, 32'h0000_0040, 32'h1234_5678, 4'b1111, 32'h104);
      issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h108);
      issue(1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0101, 32'h10C);
      drain();
      check("merge_model", 64'(mdl[16]), 64'h12BB_56DD);

      // stall: response held while further requests are offered
      hold = 1'b1;
      repeat (2) @(negedge clk);
      issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h110);
      g = 0;
      while (!resp_valid && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("stall_resp_seen", 64'(resp_valid), 64'd1);
      repeat (5) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_we    = 1'b1;
         req_addr  = 32'h0000_0040;
         req_wdata = $urandom;
         req_be    = 4'hF;
         check("stall_no_accept", 64'(req_ready), 64'd0);
         check("stall_valid_held", 64'(resp_valid), 64'd1);
      end
      @(negedge clk);
      req_valid = 1'b0;
      hold = 1'b0;
      drain();

      issue(1'b1, 32'h0000_0042, 32'hCAFE_F00D, 4'b1111, 32'h114);
      issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h118);
      issue(1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'b0000, 32'h11C);
      issue(1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'h120);
      issue(1'b0, 32'h0000_1040, 32'h0, 4'h0, 32'h124);

      for (int n = 0; n < 200; n++) begin
         a = 32'($urandom_range(0, 31)) << 2;
         if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
         issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom);
      end
      drain();

      // reset while a store to 0x80 is waiting
      issue(1'b1, 32'h0000_0080, 32'h5A5A_5A5A, 4'b1111, 32'h200);
      @(negedge clk);
      #3 reset = 1'b0;
      model_clear();
      #1;
      check("abort_resp_valid", 64'(resp_valid), 64'd0);
      check("abort_req_ready", 64'(req_ready), 64'd1);
      repeat (2) @(negedge clk);
      #3 reset = 1'b1;
      @(negedge clk);
      check("post_reset_resp_valid", 64'(resp_valid), 64'd0);
      check("post_reset_rdata", 64'(resp_rdata), 64'd0);
      issue(1'b0, 32'h0000_0080, 32'h0, 4'h0, 32'h204);
      issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h208);
      drain();

      repeat (3) @(negedge clk);
      check("pending_resp", 64'(exp_q.size()), 64'd0);
      check("pending_trace", 64'(trace_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
